nvme_cmd_issue: RTL and testbench
=================================

NVME_CMD_ISSUE -- requirements
Module: nvme_cmd_issue

Interface
REQ-001 Parameter TX_ADDR_BITS, default 10: SQ transmit-buffer word address width.
REQ-002 Parameter SQ_DEPTH, default 16: entries per I/O submission queue (power of 2); SSD0 occupies buffer words 0..4*SQ_DEPTH-1, SSD1 the next 4*SQ_DEPTH.
REQ-003 Reset is asynchronous and active-high; the block has one clock, and no other clock or reset exists.
REQ-004 axi_aclk  in  1  sole clock.
REQ-005 axi_areset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request; cmd_ready  out  1  accept (valid&ready = accept).
REQ-007 cmd_action_id  in  CMD_ACTION_ID_BITS  requesting action; cmd_ssd  in  1  target SSD (0/1); cmd_write  in  1  1=write (opcode 0x01), 0=read (0x02).
REQ-008 cmd_lba  in  64  start LBA; cmd_nlb  in  16  0-based block count; cmd_prp1, cmd_prp2  in  64 each  PRP entries.
REQ-009 sq_head0, sq_head1  in  16  SQ head pointers reported by completions (SSD0, SSD1).
REQ-010 cmd_release  in  1  credit return pulse; cmd_release_id  in  CMD_ACTION_ID_BITS  action whose completion was consumed.
REQ-011 tx_write_valid  out  1; tx_waddr  out  TX_ADDR_BITS; tx_wdata  out  128  SQE write port.
REQ-012 sq_doorbell_valid  out  1  one-cycle pulse; sq_doorbell_index  out  SQ_INDEX_BITS  physical queue index; sq_doorbell_tail  out  16  new tail.

Function
REQ-013 The block SHALL use a per-action req_id counter (REQ_ID_BITS), stamped into each command and incremented after it, wrapping from TRACK_NUM-1 to 0.
REQ-014 The block SHALL use a per-action outstanding counter: +1 on accept, -1 on cmd_release for that action; both in the same cycle for the same action leaves it unchanged; a release with count 0 is ignored.
REQ-015 FSM states: IDLE, WRITE (4 beats), RING; IDLE->WRITE on accept, WRITE->RING after beat 3, RING->IDLE unconditionally; accept-to-accept minimum 6 cycles.
REQ-016 cmd_ready SHALL be 1 only in IDLE, with outstanding[cmd_action_id] < TRACK_NUM, and with SQ of cmd_ssd not full ((tail+1) mod SQ_DEPTH != head mod SQ_DEPTH); combinational from these terms.
REQ-017 On accept, all command fields SHALL be registered; later input changes do not affect the SQE.
REQ-018 cmd_id SHALL be {req_id, action_id, sq_index}, 16 bits; sq_index = CMD_SSD0_Q1 for SSD0, CMD_SSD1_Q1 for SSD1.
REQ-019 Beat b (0..3) SHALL be written on consecutive cycles at tx_waddr = cmd_ssd*4*SQ_DEPTH + tail*4 + b.
REQ-020 Beat0 layout: [7:0]=opcode, [15:8]=0, [31:16]=cmd_id, [63:32]=NSID 1, [127:64]=0.
REQ-021 Beat1 layout: [63:0]=0, [127:64]=prp1. Beat2 layout: [63:0]=prp2, [127:64]=lba.
REQ-022 Beat3 layout: [15:0]=nlb, [127:16]=0.
REQ-023 In RING the block SHALL pulse sq_doorbell_valid with that queue's index and tail+1 mod SQ_DEPTH, and advance that tail in the same cycle.
REQ-024 Doorbell SHALL follow beat3 by exactly one cycle; no doorbell without all 4 beats.

Reset
REQ-025 On axi_areset: FSM=IDLE; all tails, req_id and outstanding counters 0; cmd_ready, tx_write_valid, sq_doorbell_valid, tx_waddr, tx_wdata, sq_doorbell_index, sq_doorbell_tail all 0.
REQ-026 Reset mid-WRITE SHALL abandon the partial SQE with no doorbell; the first command after reset uses tail 0, req_id 0.

Structure
REQ-027 CMD_ACTION_ID_BITS, REQ_ID_BITS, TRACK_NUM, SQ_INDEX_BITS, CMD_SSD*_Q1, opcode constants and SQE beat layout SHALL live in the shared nvme defines package.
REQ-028 One sub-module nvme_sqe_build (combinational 128-bit beat mux from registered fields and beat index) is natural; FSM and counters stay in nvme_cmd_issue.

Verification
REQ-029 Scenario: after reset, read action 2 on SSD0, lba 0x10, nlb 7 -> 4 writes at addr 0..3, beat0[31:16]=0x0021, doorbell index CMD_SSD0_Q1, tail 1.
REQ-030 Scenario: TRACK_NUM accepts on action 5, no releases -> cmd_ready 0 for action 5, 1 for action 6; one release id 5 -> ready returns next cycle.
REQ-031 Scenario: SSD1 sq_head1=0, issue SQ_DEPTH-1 commands -> ready drops; set sq_head1=1 -> one more accepted, tail wraps to 0.
REQ-032 Scenario: issue TRACK_NUM+1 commands with releases on action 3 -> req_id sequence 0..TRACK_NUM-1, 0.
REQ-033 Scenario: accept and release on action 1 in same cycle, and reset asserted during beat 2 -> count unchanged; after reset no doorbell, tail/req_id restart at 0.

Source files
------------

// File: rtl/nvme_cmd_issue_pkg.sv
// Shared NVMe command-issue definitions.
// Holds the action/request-id sizing, submission-queue indices, opcodes,
// the FSM state type, the registered-command record and the 64-byte SQE
// beat layout used by the command issue block and its SQE builder.
package nvme_cmd_issue_pkg;

    localparam int CMD_ACTION_ID_BITS = 4;
    localparam int REQ_ID_BITS        = 8;
    localparam int TRACK_NUM          = 16;
    localparam int SQ_INDEX_BITS      = 4;
    localparam int CMD_ID_BITS        = REQ_ID_BITS + CMD_ACTION_ID_BITS + SQ_INDEX_BITS;

    // Outstanding counters must be able to hold TRACK_NUM itself.
    localparam int OUTST_BITS = $clog2(TRACK_NUM + 1);

    // Physical I/O submission queue index used for each SSD.
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD0_Q1 = 4'd1;
    localparam logic [SQ_INDEX_BITS-1:0] CMD_SSD1_Q1 = 4'd2;

    localparam logic [7:0]  NVME_OPC_WRITE = 8'h01;
    localparam logic [7:0]  NVME_OPC_READ  = 8'h02;
    localparam logic [31:0] NVME_NSID      = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RING  = 2'd2
    } issue_state_e;

    // Command fields captured at accept time.
    typedef struct packed {
        logic                   write;
        logic                   ssd;
        logic [CMD_ID_BITS-1:0] cmd_id;
        logic [63:0]            lba;
        logic [15:0]            nlb;
        logic [63:0]            prp1;
        logic [63:0]            prp2;
    } sqe_fields_t;

    function automatic logic [7:0] sqe_opcode(input logic write);
        return write ? NVME_OPC_WRITE : NVME_OPC_READ;
    endfunction

    function automatic logic [CMD_ID_BITS-1:0] make_cmd_id(
        input logic [REQ_ID_BITS-1:0]        req_id,
        input logic [CMD_ACTION_ID_BITS-1:0] action_id,
        input logic                          ssd
    );
        return {req_id, action_id, (ssd ? CMD_SSD1_Q1 : CMD_SSD0_Q1)};
    endfunction

    // One 128-bit quarter of the 64-byte submission queue entry.
    function automatic logic [127:0] sqe_beat(
        input logic [1:0]             beat,
        input logic [7:0]             opcode,
        input logic [CMD_ID_BITS-1:0] cmd_id,
        input logic [63:0]            prp1,
        input logic [63:0]            prp2,
        input logic [63:0]            lba,
        input logic [15:0]            nlb
    );
        logic [127:0] b;
        b = '0;
        case (beat)
            2'd0:    b = {64'h0, NVME_NSID, cmd_id, 8'h00, opcode};
            2'd1:    b = {prp1, 64'h0};
            2'd2:    b = {lba, prp2};
            default: b = {112'h0, nlb};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nvme_cmd_issue_if.sv
// Command-issue bus bundle.
// Carries the command request handshake (cmd_valid/cmd_ready), command
// fields, SQ head pointers, credit-return pulse, the SQE transmit-buffer
// write port and the doorbell pulse.
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both 1; cmd_ready never depends on cmd_valid.
// master = command source / buffer sink, slave = nvme_cmd_issue.
interface nvme_cmd_issue_if
    import nvme_cmd_issue_pkg::*;
#(
    parameter int TX_ADDR_BITS = 10
) ();

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [CMD_ACTION_ID_BITS-1:0] cmd_action_id;
    logic                          cmd_ssd;
    logic                          cmd_write;
    logic [63:0]                   cmd_lba;
    logic [15:0]                   cmd_nlb;
    logic [63:0]                   cmd_prp1;
    logic [63:0]                   cmd_prp2;
    logic [15:0]                   sq_head0;
    logic [15:0]                   sq_head1;
    logic                          cmd_release;
    logic [CMD_ACTION_ID_BITS-1:0] cmd_release_id;
    logic                          tx_write_valid;
    logic [TX_ADDR_BITS-1:0]       tx_waddr;
    logic [127:0]                  tx_wdata;
    logic                          sq_doorbell_valid;
    logic [SQ_INDEX_BITS-1:0]      sq_doorbell_index;
    logic [15:0]                   sq_doorbell_tail;

    modport master (
        output cmd_valid, cmd_action_id, cmd_ssd, cmd_write, cmd_lba, cmd_nlb,
               cmd_prp1, cmd_prp2, sq_head0, sq_head1, cmd_release, cmd_release_id,
        input  cmd_ready, tx_write_valid, tx_waddr, tx_wdata,
               sq_doorbell_valid, sq_doorbell_index, sq_doorbell_tail
    );

    modport slave (
        input  cmd_valid, cmd_action_id, cmd_ssd, cmd_write, cmd_lba, cmd_nlb,
               cmd_prp1, cmd_prp2, sq_head0, sq_head1, cmd_release, cmd_release_id,
        output cmd_ready, tx_write_valid, tx_waddr, tx_wdata,
               sq_doorbell_valid, sq_doorbell_index, sq_doorbell_tail
    );

endinterface

// File: rtl/nvme_cmd_issue_sqe_build.sv
// nvme_sqe_build: combinational SQE beat mux.
// Ports: beat (0..3), registered opcode/cmd_id/prp1/prp2/lba/nlb in,
// data = the 128-bit beat to write at that index.
module nvme_sqe_build
    import nvme_cmd_issue_pkg::*;
(
    input  logic [1:0]             beat,
    input  logic [7:0]             opcode,
    input  logic [CMD_ID_BITS-1:0] cmd_id,
    input  logic [63:0]            prp1,
    input  logic [63:0]            prp2,
    input  logic [63:0]            lba,
    input  logic [15:0]            nlb,
    output logic [127:0]           data
);

    assign data = sqe_beat(beat, opcode, cmd_id, prp1, prp2, lba, nlb);

endmodule

// File: rtl/nvme_cmd_issue.sv
// NVMe command issue engine.
// Accepts one command at a time, writes its 64-byte SQE as four 128-bit
// beats into the SQ transmit buffer of the chosen SSD, then rings that
// queue's doorbell with the advanced tail. Tracks a per-action request id
// and a per-action outstanding count (credit limit TRACK_NUM).
// Ports: axi_aclk, axi_areset (async, active high), bus (slave modport of
// nvme_cmd_issue_if), dbg_state (current FSM state).
module nvme_cmd_issue
    import nvme_cmd_issue_pkg::*;
#(
    parameter int TX_ADDR_BITS = 10,
    parameter int SQ_DEPTH     = 16
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    nvme_cmd_issue_if.slave       bus,
    output issue_state_e          dbg_state
);

    localparam int NUM_ACTIONS = 1 << CMD_ACTION_ID_BITS;
    localparam int TAIL_W      = $clog2(SQ_DEPTH);
    localparam int SSD_SHIFT   = TAIL_W + 2;

    issue_state_e            state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    sqe_fields_t             fields_q, fields_d;
    logic [TAIL_W-1:0]       tail_q [2];
    logic [TAIL_W-1:0]       tail_d [2];
    logic [REQ_ID_BITS-1:0]  req_id_q [NUM_ACTIONS];
    logic [REQ_ID_BITS-1:0]  req_id_d [NUM_ACTIONS];
    logic [OUTST_BITS-1:0]   outst_q [NUM_ACTIONS];
    logic [OUTST_BITS-1:0]   outst_d [NUM_ACTIONS];

    logic [TAIL_W-1:0]       head_mod [2];
    logic                    sq_full [2];
    logic                    cmd_ready_w;
    logic                    accept;
    logic [TAIL_W-1:0]       cur_tail;
    logic [TAIL_W-1:0]       next_tail;
    logic [31:0]             addr_full;
    logic [7:0]              opcode;
    logic [127:0]            beat_data;
    logic                    tx_write_valid_w;
    logic [TX_ADDR_BITS-1:0] tx_waddr_w;
    logic [127:0]            tx_wdata_w;
    logic                    db_valid_w;
    logic [SQ_INDEX_BITS-1:0] db_index_w;
    logic [15:0]             db_tail_w;
    logic                    unused_bits;

    // Only the low bits of the head pointers matter: queue positions wrap
    // at SQ_DEPTH.
    assign head_mod[0] = bus.sq_head0[TAIL_W-1:0];
    assign head_mod[1] = bus.sq_head1[TAIL_W-1:0];
    assign sq_full[0]  = (tail_q[0] + TAIL_W'(1)) == head_mod[0];
    assign sq_full[1]  = (tail_q[1] + TAIL_W'(1)) == head_mod[1];

    assign cmd_ready_w = !axi_areset
                      && (state_q == ST_IDLE)
                      && (outst_q[bus.cmd_action_id] < OUTST_BITS'(TRACK_NUM))
                      && !sq_full[bus.cmd_ssd];
    assign accept      = bus.cmd_valid && cmd_ready_w;

    // The tail of the active queue is stable until RING, so it doubles as
    // the SQE slot for all four beats.
    assign cur_tail  = tail_q[fields_q.ssd];
    assign next_tail = cur_tail + TAIL_W'(1);
    assign addr_full = (32'(fields_q.ssd) << SSD_SHIFT) | (32'(cur_tail) << 2) | 32'(beat_q);
    assign opcode    = sqe_opcode(fields_q.write);

    assign unused_bits = ^{bus.sq_head0[15:TAIL_W], bus.sq_head1[15:TAIL_W],
                           addr_full[31:TX_ADDR_BITS]};

    nvme_sqe_build u_sqe_build (
        .beat   (beat_q),
        .opcode (opcode),
        .cmd_id (fields_q.cmd_id),
        .prp1   (fields_q.prp1),
        .prp2   (fields_q.prp2),
        .lba    (fields_q.lba),
        .nlb    (fields_q.nlb),
        .data   (beat_data)
    );

    // FSM, field capture, req_id and tail updates.
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        fields_d         = fields_q;
        tail_d           = tail_q;
        req_id_d         = req_id_q;
        tx_write_valid_w = 1'b0;
        tx_waddr_w       = '0;
        tx_wdata_w       = '0;
        db_valid_w       = 1'b0;
        db_index_w       = '0;
        db_tail_w        = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d        = ST_WRITE;
                    beat_d         = 2'd0;
                    fields_d.write = bus.cmd_write;
                    fields_d.ssd   = bus.cmd_ssd;
                    fields_d.cmd_id = make_cmd_id(req_id_q[bus.cmd_action_id],
                                                  bus.cmd_action_id, bus.cmd_ssd);
                    fields_d.lba   = bus.cmd_lba;
                    fields_d.nlb   = bus.cmd_nlb;
                    fields_d.prp1  = bus.cmd_prp1;
                    fields_d.prp2  = bus.cmd_prp2;
                    req_id_d[bus.cmd_action_id] =
                        (req_id_q[bus.cmd_action_id] == REQ_ID_BITS'(TRACK_NUM - 1))
                        ? '0 : req_id_q[bus.cmd_action_id] + REQ_ID_BITS'(1);
                end
            end
            ST_WRITE: begin
                tx_write_valid_w = 1'b1;
                tx_waddr_w       = addr_full[TX_ADDR_BITS-1:0];
                tx_wdata_w       = beat_data;
                if (beat_q == 2'd3) begin
                    state_d = ST_RING;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_RING: begin
                db_valid_w             = 1'b1;
                db_index_w             = fields_q.ssd ? CMD_SSD1_Q1 : CMD_SSD0_Q1;
                db_tail_w              = 16'(next_tail);
                tail_d[fields_q.ssd]   = next_tail;
                state_d                = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding credits: accept and a valid release on the same action in
    // the same cycle cancel; a release against a zero count is dropped.
    always_comb begin
        outst_d = outst_q;
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            if ((accept && (bus.cmd_action_id == CMD_ACTION_ID_BITS'(a)))
                && !(bus.cmd_release && (bus.cmd_release_id == CMD_ACTION_ID_BITS'(a))
                     && (outst_q[a] != '0))) begin
                outst_d[a] = outst_q[a] + OUTST_BITS'(1);
            end else if (!(accept && (bus.cmd_action_id == CMD_ACTION_ID_BITS'(a)))
                && (bus.cmd_release && (bus.cmd_release_id == CMD_ACTION_ID_BITS'(a))
                    && (outst_q[a] != '0))) begin
                outst_d[a] = outst_q[a] - OUTST_BITS'(1);
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q   <= ST_IDLE;
            beat_q    <= 2'd0;
            fields_q  <= '0;
            tail_q[0] <= '0;
            tail_q[1] <= '0;
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                req_id_q[a] <= '0;
                outst_q[a]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            fields_q  <= fields_d;
            tail_q[0] <= tail_d[0];
            tail_q[1] <= tail_d[1];
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                req_id_q[a] <= req_id_d[a];
                outst_q[a]  <= outst_d[a];
            end
        end
    end

    assign bus.cmd_ready         = cmd_ready_w;
    assign bus.tx_write_valid    = tx_write_valid_w;
    assign bus.tx_waddr          = tx_waddr_w;
    assign bus.tx_wdata          = tx_wdata_w;
    assign bus.sq_doorbell_valid = db_valid_w;
    assign bus.sq_doorbell_index = db_index_w;
    assign bus.sq_doorbell_tail  = db_tail_w;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_nvme_cmd_issue.sv
module tb_nvme_cmd_issue;
    import nvme_cmd_issue_pkg::*;

    localparam int TXW = 10;
    localparam int SQD = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    issue_state_e dbg_state;
    always #5 clk = ~clk;

    nvme_cmd_issue_if #(.TX_ADDR_BITS(TXW)) bus ();

    nvme_cmd_issue #(.TX_ADDR_BITS(TXW), .SQ_DEPTH(SQD)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [TXW+127:0] exp_wr_q[$];
    logic [19:0]      exp_db_q[$];

    // reference model: queue tails, per-action request ids and credits
    int m_tail[2];
    int m_req[16];
    int m_out[16];
    int m_head[2];

    logic [TXW-1:0] obs_addr0;
    logic [127:0]   obs_beat0;
    logic [19:0]    obs_db;
    logic           prev_beat3;

    task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit model_ready(int a, int s);
        return (m_out[a] < TRACK_NUM) && (((m_tail[s] + 1) % SQD) != (m_head[s] % SQD));
    endfunction

    function automatic logic [127:0] model_beat(int b, int a, int s, bit wr, logic [63:0] lba,
                                                logic [15:0] nlb, logic [63:0] p1, logic [63:0] p2,
                                                int req);
        int cid;
        logic [127:0] r;
        cid = req * 256 + a * 16 + (s != 0 ? 2 : 1);
        case (b)
            0:       r = 128'(wr ? 1 : 2) + (128'(cid) << 16) + (128'(1) << 32);
            1:       r = 128'(p1) << 64;
            2:       r = (128'(lba) << 64) + 128'(p2);
            default: r = 128'(nlb);
        endcase
        return r;
    endfunction

    // monitor: compare every buffer write and doorbell against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_write_valid) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", 138'(bus.tx_write_valid), 138'(0));
                else check("tx_write", {bus.tx_waddr, bus.tx_wdata}, exp_wr_q.pop_front());
                if (bus.tx_waddr[1:0] == 2'd0) begin
                    obs_addr0 = bus.tx_waddr;
                    obs_beat0 = bus.tx_wdata;
                end
            end
            if (bus.sq_doorbell_valid) begin
                check("db_after_beat3", 138'(prev_beat3), 138'(1));
                check("beats_before_db", 138'(exp_wr_q.size()), 138'(0));
                if (exp_db_q.size() == 0) check("unexpected_doorbell", 138'(bus.sq_doorbell_valid), 138'(0));
                else check("doorbell", {bus.sq_doorbell_index, bus.sq_doorbell_tail}, exp_db_q.pop_front());
                obs_db = {bus.sq_doorbell_index, bus.sq_doorbell_tail};
            end
            prev_beat3 = bus.tx_write_valid && (bus.tx_waddr[1:0] == 2'd3);
        end else begin
            prev_beat3 = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_head(input int s, input int v);
        m_head[s] = v;
        if (s == 0) bus.sq_head0 = 16'(v);
        else        bus.sq_head1 = 16'(v);
    endtask

    task automatic drain();
        set_head(0, m_tail[0] + 16 * $urandom_range(0, 3));
        set_head(1, m_tail[1] + 16 * $urandom_range(0, 3));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_release = 1'b0;
        exp_wr_q.delete();
        exp_db_q.delete();
        for (int i = 0; i < 2; i++) m_tail[i] = 0;
        for (int i = 0; i < 16; i++) begin
            m_req[i] = 0;
            m_out[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_cmd(input int a, input int s, input bit wr, input logic [63:0] lba,
                          input logic [15:0] nlb, input logic [63:0] p1, input logic [63:0] p2,
                          input bit rel, input int rel_id, output bit accepted);
        bit er;
        @(negedge clk);
        bus.cmd_action_id  = CMD_ACTION_ID_BITS'(a);
        bus.cmd_ssd        = s[0];
        bus.cmd_write      = wr;
        bus.cmd_lba        = lba;
        bus.cmd_nlb        = nlb;
        bus.cmd_prp1       = p1;
        bus.cmd_prp2       = p2;
        bus.cmd_release    = rel;
        bus.cmd_release_id = CMD_ACTION_ID_BITS'(rel_id);
        bus.cmd_valid      = 1'b0;
        #1;
        er = model_ready(a, s);
        check("cmd_ready", 138'(bus.cmd_ready), 138'(er));
        bus.cmd_valid = er;
        @(posedge clk);
        if (rel && m_out[rel_id] > 0) m_out[rel_id]--;
        if (er) begin
            for (int b = 0; b < 4; b++)
                exp_wr_q.push_back({TXW'(s * 4 * SQD + m_tail[s] * 4 + b),
                                    model_beat(b, a, s, wr, lba, nlb, p1, p2, m_req[a])});
            m_tail[s] = (m_tail[s] + 1) % SQD;
            exp_db_q.push_back({4'(s != 0 ? 2 : 1), 16'(m_tail[s])});
            m_req[a] = (m_req[a] + 1) % TRACK_NUM;
            m_out[a]++;
        end
        #1;
        // scramble inputs: the SQE must come from the registered copy
        bus.cmd_valid   = 1'b0;
        bus.cmd_release = 1'b0;
        bus.cmd_lba     = {$urandom, $urandom};
        bus.cmd_prp1    = {$urandom, $urandom};
        bus.cmd_prp2    = {$urandom, $urandom};
        bus.cmd_nlb     = 16'($urandom);
        bus.cmd_write   = ~wr;
        bus.cmd_ssd     = ~s[0];
        if (er) begin
            repeat (5) @(negedge clk);
            #2;
        end
        accepted = er;
    endtask

    task automatic do_release(input int id);
        @(negedge clk);
        bus.cmd_release    = 1'b1;
        bus.cmd_release_id = CMD_ACTION_ID_BITS'(id);
        @(posedge clk);
        if (m_out[id] > 0) m_out[id]--;
        #1 bus.cmd_release = 1'b0;
    endtask

    task automatic probe(input string name, input int a, input int s, input bit exp);
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
        bus.cmd_action_id = CMD_ACTION_ID_BITS'(a);
        bus.cmd_ssd       = s[0];
        #1 check(name, 138'(bus.cmd_ready), 138'(exp));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int             a;
        int             s;
        bit             wr;
        logic [63:0]    lba;
        logic [15:0]    nlb;
        logic [TXW-1:0] base;
        logic [15:0]    cid;
        logic [15:0]    db_tail;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        vecs[0] = '{2, 0, 1'b0, 64'h10, 16'd7, 10'd0, 16'h0021, 16'd1};
        vecs[1] = '{2, 1, 1'b1, 64'h1234_5678_9abc_def0, 16'hffff, 10'd64, 16'h0122, 16'd1};
        vecs[2] = '{7, 0, 1'b1, 64'h0, 16'd0, 10'd4, 16'h0071, 16'd2};
        vecs[3] = '{2, 0, 1'b0, 64'hffff_ffff_ffff_fffe, 16'd3, 10'd8, 16'h0221, 16'd3};

        bus.cmd_valid = 1'b1; bus.cmd_action_id = '0; bus.cmd_ssd = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_lba = '0; bus.cmd_nlb = '0; bus.cmd_prp1 = '0; bus.cmd_prp2 = '0;
        bus.cmd_release = 1'b0; bus.cmd_release_id = '0;
        set_head(0, 0);
        set_head(1, 0);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 138'(bus.cmd_ready), 138'(0));
        check("rst_tx_valid", 138'(bus.tx_write_valid), 138'(0));
        check("rst_tx_waddr", 138'(bus.tx_waddr), 138'(0));
        check("rst_tx_wdata", 138'(bus.tx_wdata), 138'(0));
        check("rst_db_valid", 138'(bus.sq_doorbell_valid), 138'(0));
        check("rst_db_index", 138'(bus.sq_doorbell_index), 138'(0));
        check("rst_db_tail", 138'(bus.sq_doorbell_tail), 138'(0));
        check("rst_state", 138'(dbg_state), 138'(ST_IDLE));
        do_reset();

        // table-driven commands with hand-computed results
        for (int i = 0; i < 4; i++) begin
            do_cmd(vecs[i].a, vecs[i].s, vecs[i].wr, vecs[i].lba, vecs[i].nlb,
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, ok);
            check("vec_accept", 138'(ok), 138'(1));
            check("vec_base_addr", 138'(obs_addr0), 138'(vecs[i].base));
            check("vec_cmd_id", 138'(obs_beat0[31:16]), 138'(vecs[i].cid));
            check("vec_opcode", 138'(obs_beat0[7:0]), 138'(vecs[i].wr ? 1 : 2));
            check("vec_db", 138'(obs_db), 138'({4'(vecs[i].s != 0 ? 2 : 1), vecs[i].db_tail}));
        end

        // credit limit on one action
        do_reset();
        for (int i = 0; i < TRACK_NUM; i++) begin
            drain();
            do_cmd(5, i % 2, 1'b1, 64'(i), 16'(i), 64'h0, 64'h0, 1'b0, 0, ok);
        end
        drain();
        probe("credit_full_a5", 5, 0, 1'b0);
        probe("credit_other_a6", 6, 0, 1'b1);
        do_release(5);
        probe("credit_return_a5", 5, 0, 1'b1);

        // SQ full on SSD1 and tail wrap
        do_reset();
        set_head(0, 0);
        set_head(1, 0);
        for (int i = 0; i < SQD - 1; i++) begin
            do_cmd(i, 1, 1'b0, 64'(i * 8), 16'd1, 64'h0, 64'h0, 1'b0, 0, ok);
            check("sq_fill_accept", 138'(ok), 138'(1));
        end
        probe("sq_full_ready", 0, 1, 1'b0);
        set_head(1, 1);
        do_cmd(15, 1, 1'b1, 64'h55, 16'd2, 64'h1, 64'h2, 1'b0, 0, ok);
        check("sq_wrap_accept", 138'(ok), 138'(1));
        check("sq_wrap_addr", 138'(obs_addr0), 138'(64 + 15 * 4));
        check("sq_wrap_tail", 138'(obs_db[15:0]), 138'(0));
        probe("sq_full_again", 1, 1, 1'b0);

        // req_id sequence with releases
        do_reset();
        for (int i = 0; i <= TRACK_NUM; i++) begin
            drain();
            do_cmd(3, i % 2, 1'b0, 64'(i), 16'd0, 64'h0, 64'h0, 1'b0, 0, ok);
            check("req_id_seq", 138'(obs_beat0[31:24]), 138'(i % TRACK_NUM));
            do_release(3);
        end

        // accept + release same action same cycle leaves count unchanged
        do_reset();
        drain();
        do_cmd(1, 0, 1'b0, 64'h1, 16'd0, 64'h0, 64'h0, 1'b0, 0, ok);
        drain();
        do_cmd(1, 1, 1'b0, 64'h2, 16'd0, 64'h0, 64'h0, 1'b1, 1, ok);
        for (int i = 0; i < TRACK_NUM - 1; i++) begin
            drain();
            do_cmd(1, i % 2, 1'b1, 64'(i), 16'd0, 64'h0, 64'h0, 1'b0, 0, ok);
        end
        drain();
        probe("same_cycle_count", 1, 0, 1'b0);

        // reset during beat 2: no doorbell, counters restart
        do_reset();
        drain();
        @(negedge clk);
        bus.cmd_action_id = 4'd9; bus.cmd_ssd = 1'b0; bus.cmd_write = 1'b1;
        bus.cmd_lba = 64'h77; bus.cmd_nlb = 16'd5; bus.cmd_prp1 = 64'h3; bus.cmd_prp2 = 64'h4;
        bus.cmd_valid = 1'b1;
        for (int b = 0; b < 3; b++)
            exp_wr_q.push_back({TXW'(b), model_beat(b, 9, 0, 1'b1, 64'h77, 16'd5, 64'h3, 64'h4, 0)});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("partial_beats_seen", 138'(exp_wr_q.size()), 138'(0));
        do_reset();
        repeat (8) @(negedge clk);
        check("post_rst_state", 138'(dbg_state), 138'(ST_IDLE));
        drain();
        do_cmd(9, 0, 1'b0, 64'h88, 16'd1, 64'h0, 64'h0, 1'b0, 0, ok);
        check("post_rst_addr", 138'(obs_addr0), 138'(0));
        check("post_rst_req_id", 138'(obs_beat0[31:24]), 138'(0));
        check("post_rst_db_tail", 138'(obs_db[15:0]), 138'(1));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 70; i++) begin
            int s;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       set_head(s, m_tail[s] + 1);
                1:       ;
                default: set_head(s, (m_tail[s] + $urandom_range(2, 16)) % SQD + 16 * $urandom_range(0, 100));
            endcase
            do_cmd($urandom_range(0, 1), s, 1'($urandom), {$urandom, $urandom}, 16'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 9) < 3), $urandom_range(0, 1), ok);
        end

        repeat (3) @(negedge clk);
        check("exp_wr_empty", 138'(exp_wr_q.size()), 138'(0));
        check("exp_db_empty", 138'(exp_db_q.size()), 138'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
